// File: rtl/sqrt2_host_seq.sv
// Host-side sequencer for the fp16 sqrt core: launches one operand over the shared IO_DATA bus,
// captures root and flags, returns them over valid/ready. Optional abort timer: SQRT_SEQ_TIMEOUT_EN.
module sqrt2_host_seq #(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_nan,
   output logic        out_pinf,
   output logic        out_ninf,
   output logic        out_timeout,
   inout  wire  [15:0] IO_DATA,
   output logic        SQRT_ENABLE,
   input  logic        SQRT_RESULT,
   input  logic        SQRT_NAN,
   input  logic        SQRT_PINF,
   input  logic        SQRT_NINF
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DRIVE   = 3'd1,
      S_WAIT    = 3'd2,
      S_SETTLE  = 3'd3,
      S_HOLD    = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] operand_q, operand_d;
   logic        enable_q, enable_d;
   logic        drive_q, drive_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_data_q, out_data_d;
   logic        out_nan_q, out_nan_d;
   logic        out_pinf_q, out_pinf_d;
   logic        out_ninf_q, out_ninf_d;
   logic        out_timeout_q, out_timeout_d;

`ifdef SQRT_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // Next-state, capture and registered bus/enable controls
   always_comb begin
      state_d       = state_q;
      operand_d     = operand_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_nan_d     = out_nan_q;
      out_pinf_d    = out_pinf_q;
      out_ninf_d    = out_ninf_q;
      out_timeout_d = out_timeout_q;
`ifdef SQRT_SEQ_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               operand_d = in_data;
               state_d   = S_DRIVE;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_DRIVE: begin
`ifdef SQRT_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
`ifdef SQRT_SEQ_TIMEOUT_EN
            cnt_d = cnt_q + CW'(1);
            if (SQRT_RESULT) begin
               state_d = S_SETTLE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               // Abort: present a quiet NaN with the timeout flag
               out_valid_d   = 1'b1;
               out_data_d    = 16'hFE00;
               out_nan_d     = 1'b1;
               out_pinf_d    = 1'b0;
               out_ninf_d    = 1'b0;
               out_timeout_d = 1'b1;
               state_d       = S_HOLD;
            end else begin
               state_d = S_WAIT;
            end
`else
            if (SQRT_RESULT) begin
               state_d = S_SETTLE;
            end else begin
               state_d = S_WAIT;
            end
`endif
         end
         S_SETTLE: begin
            // Special inputs put data on the bus one negedge after RESULT, so capture here
            out_valid_d   = 1'b1;
            out_data_d    = IO_DATA;
            out_nan_d     = SQRT_NAN;
            out_pinf_d    = SQRT_PINF;
            out_ninf_d    = SQRT_NINF;
            out_timeout_d = 1'b0;
            state_d       = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_RELEASE;
            end else begin
               state_d     = S_HOLD;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      enable_d = (state_d == S_DRIVE) || (state_d == S_WAIT) ||
                 (state_d == S_SETTLE) || (state_d == S_HOLD);
      drive_d  = (state_d == S_DRIVE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         operand_q     <= 16'h0000;
         enable_q      <= 1'b0;
         drive_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 16'h0000;
         out_nan_q     <= 1'b0;
         out_pinf_q    <= 1'b0;
         out_ninf_q    <= 1'b0;
         out_timeout_q <= 1'b0;
`ifdef SQRT_SEQ_TIMEOUT_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         operand_q     <= operand_d;
         enable_q      <= enable_d;
         drive_q       <= drive_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_nan_q     <= out_nan_d;
         out_pinf_q    <= out_pinf_d;
         out_ninf_q    <= out_ninf_d;
         out_timeout_q <= out_timeout_d;
`ifdef SQRT_SEQ_TIMEOUT_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign IO_DATA     = drive_q ? operand_q : 16'bz;
   assign SQRT_ENABLE = enable_q;
   assign in_ready    = (state_q == S_IDLE) && !RST;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_nan     = out_nan_q;
   assign out_pinf    = out_pinf_q;
   assign out_ninf    = out_ninf_q;
`ifdef SQRT_SEQ_TIMEOUT_EN
   assign out_timeout = out_timeout_q;
`else
   assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt2_host_seq.sv
// Directed bench for sqrt2_host_seq with a behavioural fp16 sqrt core on a pulled-up IO_DATA bus
// (an undriven bus reads 16'hFFFF).
module tb_sqrt2_host_seq;

   localparam int CORE_LAT = 3;
   localparam int NORM_LAT = 5;

   logic        clk_s = 1'b0;
   logic        rst_s;
   logic        in_valid_s;
   logic        in_ready_s;
   logic [15:0] in_data_s;
   logic        out_valid_s;
   logic        out_ready_s;
   logic [15:0] out_data_s;
   logic        out_nan_s, out_pinf_s, out_ninf_s, out_timeout_s;
   tri1  [15:0] io_data_s;
   logic        sqrt_enable_s;

   int n_checks = 0;
   int n_errors = 0;
   int last_wait;

   // core model state
   int          core_st = 0;
   int          core_cnt = 0;
   logic [15:0] core_op = 16'h0000;
   logic [15:0] core_val = 16'h0000;
   logic        core_drv = 1'b0;
   logic        core_res = 1'b0;
   logic        core_nan = 1'b0, core_pinf = 1'b0, core_ninf = 1'b0;
   logic        core_stuck = 1'b0;
   logic        bus_busy_seen = 1'b0;
   logic        bus_x_seen = 1'b0;
   logic [19:0] core_lk;

   sqrt2_host_seq dut (
      .CLK(clk_s), .RST(rst_s),
      .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
      .out_nan(out_nan_s), .out_pinf(out_pinf_s), .out_ninf(out_ninf_s),
      .out_timeout(out_timeout_s), .IO_DATA(io_data_s), .SQRT_ENABLE(sqrt_enable_s),
      .SQRT_RESULT(core_res), .SQRT_NAN(core_nan), .SQRT_PINF(core_pinf), .SQRT_NINF(core_ninf)
   );

   always #5 clk_s = ~clk_s;

   assign io_data_s = core_drv ? core_val : 16'bz;

   // {special, nan, pinf, ninf, root}
   function automatic logic [19:0] core_lookup(input logic [15:0] op);
      case (op)
         16'h4400: core_lookup = {4'b0000, 16'h4000};
         16'h3C00: core_lookup = {4'b0000, 16'h3C00};
         16'h0000: core_lookup = {4'b0000, 16'h0000};
         16'hC000: core_lookup = {4'b1100, 16'hFE00};
         16'h7C00: core_lookup = {4'b1010, 16'h7C00};
         default:  core_lookup = {4'b0000, 16'hDEAD};
      endcase
   endfunction

   assign core_lk = core_lookup(core_op);

   // Behavioural core: resets while ENABLE is low, samples the operand on the first enabled negedge
   always @(negedge clk_s) begin
      if (sqrt_enable_s !== 1'b1) begin
         core_st  <= 0;
         core_drv <= 1'b0;
         core_res <= 1'b0;
         core_nan <= 1'b0; core_pinf <= 1'b0; core_ninf <= 1'b0;
      end else begin
         case (core_st)
            0: begin
               core_op  <= io_data_s;
               core_cnt <= 1;
               core_st  <= 1;
            end
            1: begin
               if (!core_stuck) begin
                  if (core_cnt == CORE_LAT) begin
                     core_res  <= 1'b1;
                     core_val  <= core_lk[15:0];
                     core_nan  <= core_lk[18];
                     core_pinf <= core_lk[17];
                     core_ninf <= core_lk[16];
                     if (core_lk[19]) begin
                        core_st <= 2;
                     end else begin
                        if (io_data_s !== 16'hFFFF) bus_busy_seen <= 1'b1;
                        core_drv <= 1'b1;
                        core_st  <= 3;
                     end
                  end else begin
                     core_cnt <= core_cnt + 1;
                  end
               end
            end
            2: begin
               if (io_data_s !== 16'hFFFF) bus_busy_seen <= 1'b1;
               core_drv <= 1'b1;
               core_st  <= 3;
            end
            default: ;
         endcase
      end
   end

   // Bus conflict monitor
   always @(negedge clk_s) begin
      if (^io_data_s === 1'bx) bus_x_seen <= 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] op, input logic [15:0] exp_data, input logic exp_nan,
                         input logic exp_pinf, input logic exp_to, input int exp_lat, input int hold_cycles);
      int n;
      int lat;
      logic [15:0] held;
      n = 0;
      while (!in_ready_s && n < 50) begin
         @(posedge clk_s); #1;
         n++;
      end
      last_wait = n;
      check_val("accept_ready", in_ready_s, 1);
      in_valid_s = 1'b1;
      in_data_s  = op;
      @(posedge clk_s); #1;
      in_valid_s = 1'b0;
      check_val("drive_bus", io_data_s, op);
      check_val("drive_en", sqrt_enable_s, 1);
      check_val("busy_in_ready", in_ready_s, 0);
      @(posedge clk_s); #1;
      check_val("wait_bus_z", io_data_s, 16'hFFFF);
      lat = 1;
      while (!out_valid_s && lat < 100) begin
         @(posedge clk_s); #1;
         lat++;
      end
      check_val("latency", lat, exp_lat);
      check_val("out_data", out_data_s, exp_data);
      check_val("out_nan", out_nan_s, exp_nan);
      check_val("out_pinf", out_pinf_s, exp_pinf);
      check_val("out_ninf", out_ninf_s, 0);
      check_val("out_timeout", out_timeout_s, exp_to);
      held = out_data_s;
      for (int i = 0; i < hold_cycles; i++) begin
         @(posedge clk_s); #1;
         check_val("bp_valid", out_valid_s, 1);
         check_val("bp_data", out_data_s, held);
         check_val("bp_en", sqrt_enable_s, 1);
         check_val("bp_in_ready", in_ready_s, 0);
      end
      out_ready_s = 1'b1;
      @(posedge clk_s); #1;
      check_val("release_valid", out_valid_s, 0);
      check_val("release_en", sqrt_enable_s, 0);
      check_val("release_in_ready", in_ready_s, 0);
   endtask

   initial begin
      rst_s = 1'b1; in_valid_s = 1'b0; in_data_s = 16'h0000; out_ready_s = 1'b1;
      repeat (3) @(posedge clk_s);
      #1;
      check_val("rst_in_ready", in_ready_s, 0);
      check_val("rst_out_valid", out_valid_s, 0);
      check_val("rst_out_data", out_data_s, 16'h0000);
      check_val("rst_flags", {out_nan_s, out_pinf_s, out_ninf_s, out_timeout_s}, 4'b0000);
      check_val("rst_en", sqrt_enable_s, 0);
      check_val("rst_bus_z", io_data_s, 16'hFFFF);
      rst_s = 1'b0;
      @(posedge clk_s); #1;
      check_val("idle_in_ready", in_ready_s, 1);

      run_op(16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, NORM_LAT, 0);
      run_op(16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0, NORM_LAT, 0);
      run_op(16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, NORM_LAT, 0);
      // ENABLE low for RELEASE plus the single IDLE accept cycle
      check_val("en_low_gap", 1 + last_wait, 2);
      run_op(16'hC000, 16'hFE00, 1'b1, 1'b0, 1'b0, NORM_LAT, 0);
      run_op(16'h7C00, 16'h7C00, 1'b0, 1'b1, 1'b0, NORM_LAT, 0);
      run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, NORM_LAT, 0);
      out_ready_s = 1'b0;
      run_op(16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, NORM_LAT, 10);
      @(posedge clk_s); #1;
      check_val("bp_back_idle", in_ready_s, 1);

      // Reset in WAIT
      in_valid_s = 1'b1; in_data_s = 16'h3C00;
      @(posedge clk_s); #1;
      in_valid_s = 1'b0;
      repeat (2) @(posedge clk_s);
      #1;
      rst_s = 1'b1;
      @(posedge clk_s); #1;
      check_val("midrst_en", sqrt_enable_s, 0);
      check_val("midrst_valid", out_valid_s, 0);
      check_val("midrst_in_ready", in_ready_s, 0);
      rst_s = 1'b0;
      @(posedge clk_s); #1;
      check_val("midrst_idle", in_ready_s, 1);
      run_op(16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, NORM_LAT, 0);

`ifdef SQRT_SEQ_TIMEOUT_EN
      core_stuck = 1'b1;
      run_op(16'h4400, 16'hFE00, 1'b1, 1'b0, 1'b1, 33, 0);
      core_stuck = 1'b0;
      run_op(16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0, NORM_LAT, 0);
`endif

      check_val("bus_busy", bus_busy_seen, 0);
      check_val("bus_conflict", bus_x_seen, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
